uop_sequencer: RTL and testbench
================================

# uop_sequencer

Microprogram sequencer for the curve point-arithmetic engine. It fetches 20-bit micro-operations from one of three registered-output microcode ROMs (init, doubling, addition) over a shared 6-bit address bus. It evaluates each uop's execution condition against the current scalar bit, then dispatches it to the modular-arithmetic datapath with a valid/ready handshake. A program ends at the first `OPCODE_RDY` word, and the sequencer then returns to idle with `rdy` high.

## Interface
- `PROG_W`, 2: width of program selector
- `clk`  in  1  system clock; one clock domain; reset is synchronous and active-high
- `rst`  in  1  synchronous active-high reset
- `ena`  in  1  start pulse; sampled only in IDLE
- `prog_sel`  in  2  program: 0 init, 1 double, 2 add, 3 reserved (treated as error)
- `cond_bit`  in  1  current scalar bit, used by conditional uops
- `rdy`  out  1  high when idle/finished
- `err`  out  1  sticky error for last run; cleared on next accepted `ena`
- `rom_addr`  out  6  shared ROM address (registered)
- `init_data`, `dbl_data`, `add_data`  in  20 each  ROM outputs, valid one cycle after `rom_addr` changes
- `uop_valid`  out  1  uop presented to datapath
- `uop_ready`  in  1  datapath accepts/completes uop
- `uop_opcode`  out  4, `uop_src1` out 5, `uop_src2` out 5, `uop_dst` out 4: registered uop fields

## Operation
- Word layout: opcode[19:16], src1[15:11], src2[10:6], dst[5:2], exec[1:0].
- Exec encodings:
  - 00 ALWAYS
  - 01 IF_SET: issue only when `cond_bit` = 1
  - 10 IF_CLR: issue only when `cond_bit` = 0
  - 11 NEVER: skip
- `OPCODE_RDY` = 4'd0. Its exec field is ignored.
- Source mux: `prog_sel` is latched at `ena` into `prog_q`, which selects the data input. Changing `prog_sel` mid-run has no effect.
- FSM states and transitions:
  - IDLE: on `ena`, go to FETCH with `rom_addr`←0, `prog_q`←`prog_sel`, `rdy`←0, `err`←0. If `prog_sel`=3, go to IDLE with `rdy`←1, `err`←1.
  - FETCH: one cycle while the ROM registers the address; then go to DECODE.
  - DECODE (data valid):
    - RDY opcode: go to IDLE, `rdy`←1.
    - Condition false: `rom_addr`+1, go to FETCH.
    - Condition true: load uop fields, `uop_valid`←1, go to ISSUE.
  - ISSUE: hold `uop_valid` and all fields stable until `uop_valid`&`uop_ready`. Then `uop_valid`←0, `rom_addr`+1, go to FETCH.
- `cond_bit` is sampled in DECODE only. Later changes do not cancel a uop already in ISSUE.
- Address overflow: a non-RDY word decoded at address 63 terminates the run after its dispatch or skip. The sequencer goes to IDLE with `rdy`=1 and `err`=1; the address never wraps to 0.
- `ena` outside IDLE is ignored.

## Timing
- Reset values: `rdy`=1, `err`=0, `rom_addr`=0, `uop_valid`=0, all uop fields 0, state IDLE, `prog_q`=0.
- Reset mid-run aborts immediately; `uop_valid` drops on the next edge with no handshake.
- Cycle 0 = edge sampling `ena`:
  - cycle 1: FETCH
  - cycle 2: DECODE
  - cycle 3: first `uop_valid`
- Per issued uop: 2 + N cycles, where N ≥ 1 is the number of ISSUE cycles until `uop_ready`.
- Per skipped uop: 2 cycles.
- Terminating RDY: decoded in a DECODE cycle; `rdy`=1 from the following cycle.
- `uop_ready` without `uop_valid` is ignored.

## Configuration
- `UOP_SEQ_COND_EXEC_EN` defined: exec field evaluated as above.
- Undefined:
  - exec field and `cond_bit` are ignored;
  - every non-RDY word is issued, including exec=11;
  - the `cond_bit` port remains present.

## Structure
- Package `uop_seq_pkg` holds:
  - field bit positions and widths
  - `OPCODE_RDY` and exec encodings (`UOP_EXEC_ALWAYS`/`IF_SET`/`IF_CLR`/`NEVER`)
  - program-select constants
  - FSM state enum
- Sub-module `uop_seq_decode`: combinational; splits the 20-bit word into fields and outputs `is_rdy` and `do_issue` from exec and `cond_bit`. The `UOP_SEQ_COND_EXEC_EN` switch lives here.
- The top level contains the FSM, address counter, output registers and ROM-select mux.

## Test plan
- Init program (MOV,MOV,MOV at 0–2, RDY at 3), `prog_sel`=0, `uop_ready` tied 1: uops issued in cycles 3, 6 and 9 with dst RX, RY, RZ. `rdy` rises in cycle 12, `err`=0.
- Backpressure: `uop_ready` held low 5 cycles on uop 1 → `uop_valid` and fields stable for 6 cycles; the next FETCH follows the handshake edge.
- Conditional program [IF_SET A, IF_CLR B, ALWAYS C, RDY]:
  - `cond_bit`=1 → A and C issued;
  - `cond_bit`=0 → B and C issued;
  - skips cost 2 cycles each.
  - With the macro undefined, A, B and C are all issued.
- No RDY in 64 words → 64 dispatches, then `rdy`=1, `err`=1, `rom_addr` never returns to 0 mid-run. The next `ena` clears `err`.
- `prog_sel`=3 → `rdy` back to 1 in cycle 1 with `err`=1 and no `uop_valid`. `ena` pulsed during a run is ignored.
- `rst` asserted while in ISSUE → next cycle: `uop_valid`=0, `rdy`=1, `rom_addr`=0. A fresh `ena` then runs normally.

Source files
------------

// File: rtl/uop_seq_pkg.sv
// Shared constants for the microprogram sequencer: uop word layout, exec
// encodings, program selectors and the FSM state type.
package uop_seq_pkg;

  localparam int UOP_W    = 20;
  localparam int ADDR_W   = 6;
  localparam int OPC_LSB  = 16;
  localparam int OPC_W    = 4;
  localparam int SRC1_LSB = 11;
  localparam int SRC2_LSB = 6;
  localparam int SRC_W    = 5;
  localparam int DST_LSB  = 2;
  localparam int DST_W    = 4;
  localparam int EXEC_LSB = 0;
  localparam int EXEC_W   = 2;

  localparam logic [OPC_W-1:0] OPCODE_RDY = 4'd0;

  localparam logic [EXEC_W-1:0] UOP_EXEC_ALWAYS = 2'b00;
  localparam logic [EXEC_W-1:0] UOP_EXEC_IF_SET = 2'b01;
  localparam logic [EXEC_W-1:0] UOP_EXEC_IF_CLR = 2'b10;
  localparam logic [EXEC_W-1:0] UOP_EXEC_NEVER  = 2'b11;

  localparam logic [1:0] PROG_INIT = 2'd0;
  localparam logic [1:0] PROG_DBL  = 2'd1;
  localparam logic [1:0] PROG_ADD  = 2'd2;
  localparam logic [1:0] PROG_RSVD = 2'd3;

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DECODE = 2'd2,
    ST_ISSUE  = 2'd3
  } state_t;

endpackage

// File: rtl/uop_sequencer_if.sv
// Uop dispatch channel between the sequencer (master) and the modular
// arithmetic datapath (slave).
interface uop_sequencer_if;
  // Transfer occurs on a clock edge where uop_valid && uop_ready. Once raised,
  // uop_valid and all fields hold until that edge; uop_ready alone means nothing.
  logic       uop_valid;
  logic       uop_ready;
  logic [3:0] uop_opcode;
  logic [4:0] uop_src1;
  logic [4:0] uop_src2;
  logic [3:0] uop_dst;

  modport master (
    output uop_valid, uop_opcode, uop_src1, uop_src2, uop_dst,
    input  uop_ready
  );

  modport slave (
    input  uop_valid, uop_opcode, uop_src1, uop_src2, uop_dst,
    output uop_ready
  );
endinterface

// File: rtl/uop_seq_decode.sv
// Combinational uop word splitter and issue-condition evaluator.
// Exec-field evaluation is enabled by defining UOP_SEQ_COND_EXEC_EN.
module uop_seq_decode
  import uop_seq_pkg::*;
(
  input  logic [UOP_W-1:0]  word_i,
  input  logic              cond_bit_i,
  output logic [OPC_W-1:0]  opcode_o,
  output logic [SRC_W-1:0]  src1_o,
  output logic [SRC_W-1:0]  src2_o,
  output logic [DST_W-1:0]  dst_o,
  output logic              is_rdy_o,
  output logic              do_issue_o
);

  logic [EXEC_W-1:0] exec;

  assign opcode_o = word_i[OPC_LSB  +: OPC_W];
  assign src1_o   = word_i[SRC1_LSB +: SRC_W];
  assign src2_o   = word_i[SRC2_LSB +: SRC_W];
  assign dst_o    = word_i[DST_LSB  +: DST_W];
  assign exec     = word_i[EXEC_LSB +: EXEC_W];
  assign is_rdy_o = (opcode_o == OPCODE_RDY);

`ifdef UOP_SEQ_COND_EXEC_EN
  always_comb begin
    do_issue_o = 1'b0;
    case (exec)
      UOP_EXEC_ALWAYS: do_issue_o = 1'b1;
      UOP_EXEC_IF_SET: do_issue_o = cond_bit_i;
      UOP_EXEC_IF_CLR: do_issue_o = ~cond_bit_i;
      default:         do_issue_o = 1'b0;
    endcase
  end
`else
  // Unconditional build: every non-RDY word issues, exec and cond_bit are don't-care.
  logic unused_exec;
  assign unused_exec = ^{exec, cond_bit_i};
  assign do_issue_o  = 1'b1;
`endif

endmodule

// File: rtl/uop_sequencer.sv
// Microprogram sequencer: fetches uops from one of three registered ROMs,
// evaluates exec conditions and dispatches over a valid/ready channel.
module uop_sequencer
  import uop_seq_pkg::*;
#(
  parameter int PROG_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [PROG_W-1:0] prog_sel,
  input  logic              cond_bit,
  output logic              rdy,
  output logic              err,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [UOP_W-1:0]  init_data,
  input  logic [UOP_W-1:0]  dbl_data,
  input  logic [UOP_W-1:0]  add_data,
  uop_sequencer_if.master   uop,
  output state_t            dbg_state
);

  state_t            state_q;
  logic [PROG_W-1:0] prog_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [ADDR_W-1:0] rom_addr_d;
  logic              rdy_q;
  logic              err_q;
  logic              uop_valid_q;
  logic [OPC_W-1:0]  opcode_q;
  logic [SRC_W-1:0]  src1_q;
  logic [SRC_W-1:0]  src2_q;
  logic [DST_W-1:0]  dst_q;

  logic [UOP_W-1:0]  word_d;
  logic [OPC_W-1:0]  dec_opcode;
  logic [SRC_W-1:0]  dec_src1;
  logic [SRC_W-1:0]  dec_src2;
  logic [DST_W-1:0]  dec_dst;
  logic              dec_is_rdy;
  logic              dec_do_issue;
  logic              at_last;

  always_comb begin
    word_d = '0;
    case (prog_q)
      PROG_W'(PROG_INIT): word_d = init_data;
      PROG_W'(PROG_DBL):  word_d = dbl_data;
      PROG_W'(PROG_ADD):  word_d = add_data;
      default:            word_d = '0;
    endcase
  end

  uop_seq_decode u_decode (
    .word_i     (word_d),
    .cond_bit_i (cond_bit),
    .opcode_o   (dec_opcode),
    .src1_o     (dec_src1),
    .src2_o     (dec_src2),
    .dst_o      (dec_dst),
    .is_rdy_o   (dec_is_rdy),
    .do_issue_o (dec_do_issue)
  );

  assign rom_addr_d = rom_addr_q + 1'b1;
  // The last ROM word ends the run rather than wrapping to address 0.
  assign at_last    = (rom_addr_q == ADDR_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      prog_q      <= '0;
      rom_addr_q  <= '0;
      rdy_q       <= 1'b1;
      err_q       <= 1'b0;
      uop_valid_q <= 1'b0;
      opcode_q    <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      dst_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ena) begin
            if (prog_sel == PROG_W'(PROG_RSVD)) begin
              rdy_q <= 1'b1;
              err_q <= 1'b1;
            end else begin
              state_q    <= ST_FETCH;
              prog_q     <= prog_sel;
              rom_addr_q <= '0;
              rdy_q      <= 1'b0;
              err_q      <= 1'b0;
            end
          end
        end
        ST_FETCH: state_q <= ST_DECODE;
        ST_DECODE: begin
          if (dec_is_rdy) begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b1;
          end else if (dec_do_issue) begin
            state_q     <= ST_ISSUE;
            uop_valid_q <= 1'b1;
            opcode_q    <= dec_opcode;
            src1_q      <= dec_src1;
            src2_q      <= dec_src2;
            dst_q       <= dec_dst;
          end else if (at_last) begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            state_q    <= ST_FETCH;
            rom_addr_q <= rom_addr_d;
          end
        end
        ST_ISSUE: begin
          if (uop_valid_q && uop.uop_ready) begin
            uop_valid_q <= 1'b0;
            if (at_last) begin
              state_q <= ST_IDLE;
              rdy_q   <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q    <= ST_FETCH;
              rom_addr_q <= rom_addr_d;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rdy            = rdy_q;
  assign err            = err_q;
  assign rom_addr       = rom_addr_q;
  assign uop.uop_valid  = uop_valid_q;
  assign uop.uop_opcode = opcode_q;
  assign uop.uop_src1   = src1_q;
  assign uop.uop_src2   = src2_q;
  assign uop.uop_dst    = dst_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_uop_sequencer.sv
// Directed bench for uop_sequencer: ROM models, scenario tasks with inline
// checks against hand-computed cycle/field expectations, one summary line.
module tb_uop_sequencer;
  import uop_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic [1:0]  prog_sel = 2'd0;
  logic        cond_bit = 1'b0;
  logic        rdy;
  logic        err;
  logic [5:0]  rom_addr;
  logic [19:0] init_data, dbl_data, add_data;
  state_t      dbg_state;

  logic [19:0] init_rom [64];
  logic [19:0] dbl_rom  [64];
  logic [19:0] add_rom  [64];

  int vectors = 0;
  int miscompares = 0;

  int         got_cyc [$];
  logic [3:0] got_dst [$];
  int         rdy_cyc;
  bit         saw_wrap;

  uop_sequencer_if uop ();

  uop_sequencer #(.PROG_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .prog_sel  (prog_sel),
    .cond_bit  (cond_bit),
    .rdy       (rdy),
    .err       (err),
    .rom_addr  (rom_addr),
    .init_data (init_data),
    .dbl_data  (dbl_data),
    .add_data  (add_data),
    .uop       (uop),
    .dbg_state (dbg_state)
  );

  // Clock / reset and registered ROM models.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    init_data <= init_rom[rom_addr];
    dbl_data  <= dbl_rom[rom_addr];
    add_data  <= add_rom[rom_addr];
  end

  function automatic logic [19:0] mk(input logic [3:0] op, input logic [4:0] s1,
                                     input logic [4:0] s2, input logic [3:0] d,
                                     input logic [1:0] ex);
    return {op, s1, s2, d, ex};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses ena with sel, records every handshake cycle and dst, stops at rdy.
  // Cycle numbering: cycle 1 is the cycle after the edge that sampled ena.
  task automatic run_prog(input logic [1:0] sel, input int ena_at, input int max_cyc);
    bit left_zero;
    left_zero = 0;
    got_cyc.delete();
    got_dst.delete();
    rdy_cyc  = -1;
    saw_wrap = 0;
    prog_sel = sel;
    ena = 1'b1;
    tick();
    ena = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      if (uop.uop_valid && uop.uop_ready) begin
        got_cyc.push_back(c);
        got_dst.push_back(uop.uop_dst);
      end
      if (rom_addr != 6'd0) left_zero = 1;
      else if (left_zero && !rdy) saw_wrap = 1;
      if (rdy) begin
        rdy_cyc = c;
        break;
      end
      if (c == ena_at) begin
        ena = 1'b1;
        prog_sel = 2'd3;
      end else begin
        ena = 1'b0;
      end
      tick();
    end
    ena = 1'b0;
    vectors++;
    if (rdy_cyc < 0) begin
      miscompares++;
      $display("FAIL run_timeout: rdy not seen within %0d cycles", max_cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    vectors++; if (rdy !== 1'b1) begin miscompares++; $display("FAIL reset_rdy: got %b want 1", rdy); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
    vectors++; if (rom_addr !== 6'd0) begin miscompares++; $display("FAIL reset_addr: got %0d want 0", rom_addr); end
    vectors++; if (uop.uop_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", uop.uop_valid); end
    vectors++; if ({uop.uop_opcode, uop.uop_src1, uop.uop_src2, uop.uop_dst} !== 18'd0) begin
      miscompares++; $display("FAIL reset_fields: got %h want 0", {uop.uop_opcode, uop.uop_src1, uop.uop_src2, uop.uop_dst});
    end
    vectors++; if (dbg_state !== ST_IDLE) begin miscompares++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
  endtask

  // Init program with ena pulsed (reserved select) mid-run: must be ignored.
  task automatic test_init();
    int         exp_c [$];
    logic [3:0] exp_q [$];
    exp_c = '{3, 6, 9};
    exp_q = '{4'd1, 4'd2, 4'd3};
    uop.uop_ready = 1'b1;
    run_prog(2'd0, 5, 40);
    vectors++; if (got_cyc.size() !== exp_c.size()) begin miscompares++; $display("FAIL init_count: got %0d want %0d", got_cyc.size(), exp_c.size()); end
    for (int i = 0; i < exp_c.size() && i < got_cyc.size(); i++) begin
      vectors++; if (got_cyc[i] !== exp_c[i]) begin miscompares++; $display("FAIL init_cyc[%0d]: got %0d want %0d", i, got_cyc[i], exp_c[i]); end
      vectors++; if (got_dst[i] !== exp_q[i]) begin miscompares++; $display("FAIL init_dst[%0d]: got %0d want %0d", i, got_dst[i], exp_q[i]); end
    end
    vectors++; if (rdy_cyc !== 12) begin miscompares++; $display("FAIL init_rdy_cyc: got %0d want 12", rdy_cyc); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL init_err: got %b want 0", err); end
  endtask

  task automatic test_backpressure();
    int done_c;
    done_c = -1;
    uop.uop_ready = 1'b0;
    prog_sel = 2'd0;
    ena = 1'b1;
    tick();
    ena = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      if (c >= 3 && c <= 8) begin
        vectors++; if (uop.uop_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid c%0d: got %b want 1", c, uop.uop_valid); end
        vectors++; if ({uop.uop_opcode, uop.uop_src1, uop.uop_src2, uop.uop_dst} !== {4'd1, 5'd7, 5'd9, 4'd1}) begin
          miscompares++; $display("FAIL bp_fields c%0d: got %h want %h", c,
            {uop.uop_opcode, uop.uop_src1, uop.uop_src2, uop.uop_dst}, {4'd1, 5'd7, 5'd9, 4'd1});
        end
      end
      if (c == 8) uop.uop_ready = 1'b1;
      if (c == 9) begin
        vectors++; if (uop.uop_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drop: got %b want 0", uop.uop_valid); end
        vectors++; if (dbg_state !== ST_FETCH) begin miscompares++; $display("FAIL bp_fetch: got %0d want %0d", dbg_state, ST_FETCH); end
        vectors++; if (rom_addr !== 6'd1) begin miscompares++; $display("FAIL bp_addr: got %0d want 1", rom_addr); end
      end
      if (c < 9) tick();
    end
    for (int c = 9; c <= 40; c++) begin
      if (rdy) begin done_c = c; break; end
      tick();
    end
    vectors++; if (done_c !== 17) begin miscompares++; $display("FAIL bp_rdy_cyc: got %0d want 17", done_c); end
  endtask

  task automatic test_cond(input logic cb);
    int         exp_c [$];
    logic [3:0] exp_q [$];
    int         exp_rdy;
`ifdef UOP_SEQ_COND_EXEC_EN
    if (cb) begin exp_c = '{3, 8}; exp_q = '{4'd4, 4'd6}; end
    else    begin exp_c = '{5, 8}; exp_q = '{4'd5, 4'd6}; end
    exp_rdy = 11;
`else
    exp_c = '{3, 6, 9};
    exp_q = '{4'd4, 4'd5, 4'd6};
    exp_rdy = 12;
`endif
    uop.uop_ready = 1'b1;
    cond_bit = cb;
    run_prog(2'd1, 0, 40);
    vectors++; if (got_cyc.size() !== exp_c.size()) begin miscompares++; $display("FAIL cond%0b_count: got %0d want %0d", cb, got_cyc.size(), exp_c.size()); end
    for (int i = 0; i < exp_c.size() && i < got_cyc.size(); i++) begin
      vectors++; if (got_cyc[i] !== exp_c[i]) begin miscompares++; $display("FAIL cond%0b_cyc[%0d]: got %0d want %0d", cb, i, got_cyc[i], exp_c[i]); end
      vectors++; if (got_dst[i] !== exp_q[i]) begin miscompares++; $display("FAIL cond%0b_dst[%0d]: got %0d want %0d", cb, i, got_dst[i], exp_q[i]); end
    end
    vectors++; if (rdy_cyc !== exp_rdy) begin miscompares++; $display("FAIL cond%0b_rdy_cyc: got %0d want %0d", cb, rdy_cyc, exp_rdy); end
  endtask

  task automatic test_overflow();
    uop.uop_ready = 1'b1;
    run_prog(2'd2, 0, 260);
    vectors++; if (got_cyc.size() !== 64) begin miscompares++; $display("FAIL ovf_count: got %0d want 64", got_cyc.size()); end
    for (int k = 0; k < 64 && k < got_cyc.size(); k++) begin
      vectors++; if (got_cyc[k] !== 3 + 3 * k) begin miscompares++; $display("FAIL ovf_cyc[%0d]: got %0d want %0d", k, got_cyc[k], 3 + 3 * k); end
      vectors++; if (got_dst[k] !== 4'(k)) begin miscompares++; $display("FAIL ovf_dst[%0d]: got %0d want %0d", k, got_dst[k], k % 16); end
    end
    vectors++; if (rdy_cyc !== 193) begin miscompares++; $display("FAIL ovf_rdy_cyc: got %0d want 193", rdy_cyc); end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL ovf_err: got %b want 1", err); end
    vectors++; if (rom_addr !== 6'd63) begin miscompares++; $display("FAIL ovf_addr: got %0d want 63", rom_addr); end
    vectors++; if (saw_wrap !== 1'b0) begin miscompares++; $display("FAIL ovf_wrap: got %b want 0", saw_wrap); end
    prog_sel = 2'd0;
    ena = 1'b1;
    tick();
    ena = 1'b0;
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL ovf_err_clear: got %b want 0", err); end
    vectors++; if (rdy !== 1'b0) begin miscompares++; $display("FAIL ovf_rerun_rdy: got %b want 0", rdy); end
    for (int c = 1; c <= 40 && !rdy; c++) tick();
  endtask

  task automatic test_reserved();
    prog_sel = 2'd3;
    ena = 1'b1;
    tick();
    ena = 1'b0;
    vectors++; if (rdy !== 1'b1) begin miscompares++; $display("FAIL rsvd_rdy: got %b want 1", rdy); end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL rsvd_err: got %b want 1", err); end
    for (int c = 1; c <= 4; c++) begin
      vectors++; if (uop.uop_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
        miscompares++; $display("FAIL rsvd_quiet c%0d: got valid=%b state=%0d want 0/%0d", c, uop.uop_valid, dbg_state, ST_IDLE);
      end
      tick();
    end
  endtask

  task automatic test_reset_in_issue();
    uop.uop_ready = 1'b0;
    prog_sel = 2'd0;
    ena = 1'b1;
    tick();
    ena = 1'b0;
    tick();
    tick();
    vectors++; if (dbg_state !== ST_ISSUE || uop.uop_valid !== 1'b1) begin
      miscompares++; $display("FAIL rst_pre: got state=%0d valid=%b want %0d/1", dbg_state, uop.uop_valid, ST_ISSUE);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (uop.uop_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", uop.uop_valid); end
    vectors++; if (rdy !== 1'b1) begin miscompares++; $display("FAIL rst_rdy: got %b want 1", rdy); end
    vectors++; if (rom_addr !== 6'd0) begin miscompares++; $display("FAIL rst_addr: got %0d want 0", rom_addr); end
    vectors++; if (dbg_state !== ST_IDLE) begin miscompares++; $display("FAIL rst_state: got %0d want %0d", dbg_state, ST_IDLE); end
    uop.uop_ready = 1'b1;
    run_prog(2'd0, 0, 40);
    vectors++; if (got_cyc.size() !== 3) begin miscompares++; $display("FAIL rst_rerun_count: got %0d want 3", got_cyc.size()); end
    vectors++; if (rdy_cyc !== 12) begin miscompares++; $display("FAIL rst_rerun_rdy_cyc: got %0d want 12", rdy_cyc); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      init_rom[i] = '0;
      dbl_rom[i]  = '0;
      add_rom[i]  = mk(4'd3, 5'(i), 5'(63 - i), 4'(i), UOP_EXEC_ALWAYS);
    end
    init_rom[0] = mk(4'd1, 5'd7,  5'd9, 4'd1, UOP_EXEC_ALWAYS);
    init_rom[1] = mk(4'd1, 5'd8,  5'd9, 4'd2, UOP_EXEC_ALWAYS);
    init_rom[2] = mk(4'd1, 5'd10, 5'd9, 4'd3, UOP_EXEC_ALWAYS);
    init_rom[3] = mk(OPCODE_RDY, 5'd0, 5'd0, 4'd0, UOP_EXEC_NEVER);
    dbl_rom[0]  = mk(4'd2, 5'd1, 5'd2, 4'd4, UOP_EXEC_IF_SET);
    dbl_rom[1]  = mk(4'd2, 5'd3, 5'd4, 4'd5, UOP_EXEC_IF_CLR);
    dbl_rom[2]  = mk(4'd5, 5'd5, 5'd6, 4'd6, UOP_EXEC_ALWAYS);
    dbl_rom[3]  = mk(OPCODE_RDY, 5'd0, 5'd0, 4'd0, UOP_EXEC_ALWAYS);
    uop.uop_ready = 1'b0;

    test_reset();
    test_init();
    test_backpressure();
    test_cond(1'b1);
    test_cond(1'b0);
    test_overflow();
    test_reserved();
    test_reset_in_issue();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
